spi_flash_resp: RTL and testbench
=================================

Name: spi_flash_resp

Overview:
- SPI flash responder: the device-side end of the XIP flash read path; sits on the SoC SPI pins as a synthesizable flash model.
- Decodes the serial READ command (0x03) and a 24-bit address from MOSI.
- Fetches 32-bit words through a memory read port and streams them on MISO, MSB first, until chip-select rises.
- Clocked by the same system clock as the SPI master. SCK/SS/MOSI are oversampled, not used as clocks.

Parameters:
- ADDR_W, 24, width of the flash byte address.
- SYNC_STAGES, 1, register stages on SCK/SS/MOSI before edge detection (0 = single edge-detect flop only).

Ports:
- clock  in  1  system clock
- reset  in  1  reset; synchronous, active-high
- spi_sck  in  1  serial clock from master (mode 0)
- spi_ss  in  1  chip select, active-low
- spi_mosi  in  1  master-out data
- spi_miso  out  1  slave-out data
- mem_ren  out  1  one-cycle read request pulse
- mem_raddr  out  ADDR_W  word-aligned byte address, bits [1:0] = 0
- mem_rdata  in  32  read data, valid with mem_rvalid
- mem_rvalid  in  1  read data valid, arbitrary latency
- busy  out  1  high while SS is low and not in IDLE
- underrun  out  1  one-cycle pulse when a data word was needed but mem_rvalid had not arrived

Behaviour:
- Reset values: spi_miso=0, mem_ren=0, mem_raddr=0, busy=0, underrun=0; state=IDLE; bit counter=0; prefetch flag cleared.
- SCK edges are detected from the synchronized SCK (previous vs current sample).
  - Requirement on the master: SCK high and low phases each ≥ SYNC_STAGES+2 clocks. The master divider=1 setting (2 clocks per phase) is legal with SYNC_STAGES ≤ 0… 1 default → use SYNC_STAGES=0 for divider 1.
- Mode 0:
  - MOSI is sampled on the detected SCK rising edge.
  - MISO updates on the detected SCK falling edge.
  - MSB first.
- States:
  - IDLE: on SS falling → CMD, bit counter cleared.
  - CMD: shift 8 bits. After the 8th rise: 0x03 → ADDR; any other value → IGNORE.
  - ADDR: shift 24 bits.
    - On the rise that samples address bit 2: latch word address, pulse mem_ren with mem_raddr={addr[23:2],2'b00}.
    - After the 24th rise → DATA.
  - DATA:
    - On the first falling edge, load the shift register from the fetched word and drive its bit 31.
    - Each subsequent fall shifts left one bit.
    - After 32 falls, the next word (raddr+4) is loaded.
  - IGNORE: MISO held 0, no memory reads, until SS high.
- Prefetch: when a word is loaded into the shift register, issue mem_ren for raddr+4 on the next cycle. Only one read is outstanding at a time.
- Address wrap: raddr+4 wraps modulo 2^ADDR_W (0xFFFFFC → 0x000000).
- Underrun: word needed but mem_rvalid not yet seen → pulse underrun, shift 32'h0 for that word. A late mem_rvalid for that word is discarded; the next prefetch still issues.
- SS rising in any state: next cycle → IDLE, MISO=0, counter cleared.
  - An in-flight read is allowed to complete.
  - Its data is dropped, and mem_ren is not reissued.
- SS low at reset release: ignored until SS is seen high once.
- Simultaneous SS rise and SCK edge in the same cycle: SS wins, the edge is ignored.
- mem_rvalid without an outstanding request: ignored.

Optional Feature:
- Macro SPI_FLASH_FAST_READ_EN.
- Defined: command 0x0B also accepted. The flow is CMD → ADDR → DUMMY (8 SCK rises, MOSI ignored, MISO=0) → DATA. The first mem_ren is issued as for 0x03.
- Undefined: 0x0B goes to IGNORE like any unknown command.

Test Plan:
- Reset with SS high → miso=0, mem_ren=0, busy=0; SS low then high with no SCK → no mem_ren, back to IDLE.
- Send 0x03, 0x000100, 32 data clocks, memory returns 32'hDEADBEEF 1 cycle after mem_ren → exactly one mem_ren at raddr 0x000100 before the first data fall; MISO bits read 0xDEADBEEF.
- Continue 64 data clocks, word 0x000104 = 32'h12345678 → second word 0x12345678, third mem_ren at 0x000108.
- Address 0xFFFFFC with 64 data clocks → reads 0xFFFFFC then 0x000000.
- mem_rvalid delayed 100 cycles → underrun pulses once, first word reads 0x00000000, late data discarded.
- Command 0xAB, 56 clocks → MISO stays 0, no mem_ren. Same check with SS raised mid-ADDR: clean return to IDLE. With SPI_FLASH_FAST_READ_EN, 0x0B + addr 0x000010 + 8 dummy clocks → data from 0x000010.

Source files
------------

// File: rtl/spi_flash_resp_if.sv
// spi_flash_resp_if: bundles the SPI pins and the memory read port of the
// flash responder.
//   slave  modport - the responder (spi_flash_resp) side
//   master modport - the SoC side (SPI master plus backing memory)
// Signals: spi_sck/spi_ss/spi_mosi/spi_miso (mode-0 SPI, SS active-low),
//          mem_ren/mem_raddr/mem_rdata/mem_rvalid (word read port),
//          busy, underrun (status).
interface spi_flash_resp_if #(
  parameter int ADDR_W = 24
);
  logic              spi_sck;
  logic              spi_ss;
  logic              spi_mosi;
  logic              spi_miso;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_raddr;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;
  logic              busy;
  logic              underrun;

  modport slave (
    input  spi_sck, spi_ss, spi_mosi, mem_rdata, mem_rvalid,
    output spi_miso, mem_ren, mem_raddr, busy, underrun
  );

  modport master (
    output spi_sck, spi_ss, spi_mosi, mem_rdata, mem_rvalid,
    input  spi_miso, mem_ren, mem_raddr, busy, underrun
  );
endinterface

// File: rtl/spi_flash_resp.sv
// spi_flash_resp: device-side SPI flash responder for the XIP read path.
// Decodes READ (0x03) plus a 24-bit address from MOSI, fetches 32-bit words
// through the memory read port and streams them MSB first on MISO until SS
// rises. SCK/SS/MOSI are oversampled on the system clock.
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   bus (slave)        SPI pins, memory read port, busy/underrun status
// Optional feature: define SPI_FLASH_FAST_READ_EN to also accept FAST READ
// (0x0B), which inserts 8 dummy SCK cycles between address and data.
module spi_flash_resp #(
  parameter int ADDR_W      = 24,
  parameter int SYNC_STAGES = 1
) (
  input  logic            clock,
  input  logic            reset,
  spi_flash_resp_if.slave bus
);
  localparam int CNT_W = ($clog2(ADDR_W) + 1 > 6) ? $clog2(ADDR_W) + 1 : 6;
  localparam int SH_W  = (ADDR_W - 3 > 8) ? ADDR_W - 3 : 8;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_IGNORE
  } state_t;

  logic sck_s, ss_s, mosi_s;

  // Input synchronizers; SS resets low so an SS held low across reset
  // release never produces a falling edge until it has been seen high.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sck_s  = bus.spi_sck;
      assign ss_s   = bus.spi_ss;
      assign mosi_s = bus.spi_mosi;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
      always_ff @(posedge clock) begin
        if (reset) begin
          sck_sync_q <= '0;
          ss_sync_q  <= '0;
        end else begin
          sck_sync_q[0] <= bus.spi_sck;
          ss_sync_q[0]  <= bus.spi_ss;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sck_sync_q[i] <= sck_sync_q[i-1];
            ss_sync_q[i]  <= ss_sync_q[i-1];
          end
        end
      end
      always_ff @(posedge clock) begin
        mosi_sync_q[0] <= bus.spi_mosi;
        for (int i = 1; i < SYNC_STAGES; i++) mosi_sync_q[i] <= mosi_sync_q[i-1];
      end
      assign sck_s  = sck_sync_q[SYNC_STAGES-1];
      assign ss_s   = ss_sync_q[SYNC_STAGES-1];
      assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    end
  endgenerate

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SH_W-1:0]   shift_q;
  logic [ADDR_W-1:0] raddr_q, mem_raddr_q;
  logic              mem_ren_q, pend_q, drop_q, req_q;
  logic [31:0]       buf_q, out_sr_q;
  logic              buf_vld_q, miso_q, busy_q, underrun_q;
  logic              sck_q, ss_prev_q;
`ifdef SPI_FLASH_FAST_READ_EN
  logic              fast_q;
`endif

  logic              rise, fall, ss_fall, rv_take, addr2_ev, load_ev;
  logic [7:0]        cmd_d;
  logic [ADDR_W-1:0] addr_d, iss_addr_d;

  assign rise    = sck_s & ~sck_q;
  assign fall    = ~sck_s & sck_q;
  assign ss_fall = ~ss_s & ss_prev_q;

  always_comb begin
    cmd_d      = {shift_q[6:0], mosi_s};
    addr_d     = {shift_q[ADDR_W-4:0], mosi_s, 2'b00};
    // Rise that samples address bit 2 completes the word address.
    addr2_ev   = (state_q == S_ADDR) && !ss_s && rise &&
                 (cnt_q == CNT_W'(ADDR_W - 3));
    // Every 32nd fall in DATA (starting with the first) consumes a word.
    load_ev    = (state_q == S_DATA) && !ss_s && fall && (cnt_q[4:0] == 5'd0);
    iss_addr_d = addr2_ev ? addr_d : raddr_q;
    rv_take    = bus.mem_rvalid && pend_q;
  end

  // Data-path registers: serial shift-in and word shift-out.
  always_ff @(posedge clock) begin
    if (rise) shift_q <= {shift_q[SH_W-2:0], mosi_s};
    if (rv_take && !drop_q) buf_q <= bus.mem_rdata;
    if ((state_q == S_DATA) && !ss_s && fall)
      out_sr_q <= load_ev ? (buf_vld_q ? buf_q : 32'h0) : {out_sr_q[30:0], 1'b0};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      raddr_q     <= '0;
      mem_raddr_q <= '0;
      mem_ren_q   <= 1'b0;
      pend_q      <= 1'b0;
      drop_q      <= 1'b0;
      req_q       <= 1'b0;
      buf_vld_q   <= 1'b0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
      sck_q       <= 1'b0;
      ss_prev_q   <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
      fast_q      <= 1'b0;
`endif
    end else begin
      sck_q      <= sck_s;
      ss_prev_q  <= ss_s;
      mem_ren_q  <= 1'b0;
      underrun_q <= 1'b0;

      // Read completion; a response flagged for dropping never reaches buf_q.
      if (rv_take) begin
        pend_q    <= 1'b0;
        drop_q    <= 1'b0;
        buf_vld_q <= ~drop_q;
      end

      // SS high aborts everything; it takes priority over any SCK edge.
      if (ss_s && (state_q != S_IDLE)) begin
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        miso_q    <= 1'b0;
        busy_q    <= 1'b0;
        req_q     <= 1'b0;
        buf_vld_q <= 1'b0;
        drop_q    <= pend_q & ~rv_take;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (ss_fall) begin
              state_q <= S_CMD;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          S_CMD: begin
            if (rise) begin
              if (cnt_q == CNT_W'(7)) begin
                cnt_q <= '0;
                if (cmd_d == 8'h03) state_q <= S_ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
                else if (cmd_d == 8'h0B) state_q <= S_ADDR;
                else state_q <= S_IGNORE;
                fast_q <= (cmd_d == 8'h0B);
`else
                else state_q <= S_IGNORE;
`endif
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          S_ADDR: begin
            if (rise) begin
              if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                cnt_q <= '0;
`ifdef SPI_FLASH_FAST_READ_EN
                state_q <= fast_q ? S_DUMMY : S_DATA;
`else
                state_q <= S_DATA;
`endif
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          S_DUMMY: begin
            if (rise) begin
              if (cnt_q == CNT_W'(7)) begin
                cnt_q   <= '0;
                state_q <= S_DATA;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          S_DATA: begin
            if (fall) begin
              cnt_q  <= {{(CNT_W-5){1'b0}}, cnt_q[4:0] + 5'd1};
              miso_q <= load_ev ? (buf_vld_q & buf_q[31]) : out_sr_q[30];
            end
            if (load_ev) begin
              buf_vld_q <= 1'b0;
              if (!buf_vld_q) begin
                // Word not back yet: send zeros and discard it when it lands.
                underrun_q <= 1'b1;
                drop_q     <= pend_q & ~rv_take;
              end
            end
          end
          default: ;
        endcase

        // Read issue: one outstanding at a time, deferred via req_q if busy.
        if (addr2_ev || load_ev || req_q) begin
          if (pend_q && !rv_take) begin
            req_q   <= 1'b1;
            raddr_q <= iss_addr_d;
          end else begin
            mem_ren_q   <= 1'b1;
            mem_raddr_q <= iss_addr_d;
            raddr_q     <= iss_addr_d + ADDR_W'(4);
            pend_q      <= 1'b1;
            req_q       <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.spi_miso  = miso_q;
  assign bus.mem_ren   = mem_ren_q;
  assign bus.mem_raddr = mem_raddr_q;
  assign bus.busy      = busy_q;
  assign bus.underrun  = underrun_q;
endmodule

// File: tb/tb_spi_flash_resp.sv
// tb_spi_flash_resp: self-checking bench for spi_flash_resp. Acts as the SPI
// master (mode 0) and as the backing memory with configurable latency.
module tb_spi_flash_resp;
  localparam int H = 4;  // system clocks per SCK phase

  logic clk, rst;
  spi_flash_resp_if #(.ADDR_W(24)) bus ();

  spi_flash_resp dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          ndum;
    int          dclk;
    int          lat;
    logic [63:0] cap;
    int          nren;
    int          nund;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Memory model / monitor state (written only by the monitor process).
  logic [23:0] ren_log [0:255];
  int          ren_cnt, und_cnt, mcnt;
  logic [23:0] maddr;
  int          lat_cfg = 1;

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    case (a)
      24'h000100: mem_word = 32'hDEADBEEF;
      24'h000104: mem_word = 32'h12345678;
      default:    mem_word = {8'hC3, a};
    endcase
  endfunction

  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    ren_cnt = 0;
    und_cnt = 0;
    mcnt    = 0;
    maddr   = '0;
    forever begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mem_word(maddr);
        end
      end
      if (!rst && bus.mem_ren) begin
        ren_log[ren_cnt % 256] = bus.mem_raddr;
        ren_cnt++;
        maddr = bus.mem_raddr;
        mcnt  = lat_cfg;
      end
      if (!rst && bus.underrun) und_cnt++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One SCK period; MISO is sampled just before the rising edge. On the
  // last bit SS is raised while SCK is still high.
  task automatic clk_bit(input logic b, input bit last, output logic m);
    bus.spi_mosi = b;
    repeat (H) @(negedge clk);
    m = bus.spi_miso;
    bus.spi_sck = 1'b1;
    repeat (H) @(negedge clk);
    if (last) begin
      bus.spi_ss = 1'b1;
      repeat (H) @(negedge clk);
    end
    bus.spi_sck = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [6];
    logic [23:0] exp_q [$];
    logic [63:0] cap;
    logic [23:0] a;
    logic [31:0] bits40;
    logic        m, any;
    int          base, ubase;

    tbl[0] = '{8'h03, 24'h000100, 0, 32, 1,   64'h00000000_DEADBEEF, 2, 0};
    tbl[1] = '{8'h03, 24'h000100, 0, 64, 1,   64'hDEADBEEF_12345678, 3, 0};
    tbl[2] = '{8'h03, 24'hFFFFFC, 0, 64, 1,   64'hC3FFFFFC_C3000000, 3, 0};
    tbl[3] = '{8'h03, 24'h000200, 0, 64, 100, 64'h00000000_C3000204, 3, 1};
    tbl[4] = '{8'hAB, 24'h000100, 0, 24, 1,   64'h0, 0, 0};
`ifdef SPI_FLASH_FAST_READ_EN
    tbl[5] = '{8'h0B, 24'h000010, 8, 32, 1,   64'h00000000_C3000010, 2, 0};
`else
    tbl[5] = '{8'h0B, 24'h000010, 0, 24, 1,   64'h0, 0, 0};
`endif

    // Reset with SS high.
    rst = 1'b1;
    bus.spi_ss = 1'b1;
    bus.spi_sck = 1'b0;
    bus.spi_mosi = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_miso", 64'(bus.spi_miso), 64'd0);
    chk("reset_ren", 64'(bus.mem_ren), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_underrun", 64'(bus.underrun), 64'd0);
    chk("reset_raddr", 64'(bus.mem_raddr), 64'd0);

    // SS low then high, no SCK.
    base = ren_cnt;
    bus.spi_ss = 1'b0;
    repeat (6) @(negedge clk);
    chk("ss_only_busy_low", 64'(bus.busy), 64'd1);
    bus.spi_ss = 1'b1;
    repeat (6) @(negedge clk);
    chk("ss_only_busy_high", 64'(bus.busy), 64'd0);
    chk("ss_only_no_ren", 64'(ren_cnt - base), 64'd0);

    // SS raised in the middle of the address phase.
    base = ren_cnt;
    bus.spi_ss = 1'b0;
    repeat (H) @(negedge clk);
    bits40 = 32'h03000100;
    for (int i = 31; i >= 14; i--) clk_bit(bits40[i], 1'b0, m);
    repeat (H) @(negedge clk);
    bus.spi_ss = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_miso", 64'(bus.spi_miso), 64'd0);
    chk("abort_no_ren", 64'(ren_cnt - base), 64'd0);

    // SS held low across reset release: ignored until seen high.
    bus.spi_ss = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    base = ren_cnt;
    any = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      clk_bit(bits40[i], 1'b0, m);
      any = any | m;
    end
    for (int i = 0; i < 16; i++) begin
      clk_bit(1'b1, 1'b0, m);
      any = any | m;
    end
    chk("ss_low_rst_busy", 64'(bus.busy), 64'd0);
    chk("ss_low_rst_no_ren", 64'(ren_cnt - base), 64'd0);
    chk("ss_low_rst_miso", 64'(any), 64'd0);
    bus.spi_ss = 1'b1;
    repeat (10) @(negedge clk);

    // Table-driven transactions with an address scoreboard.
    for (int v = 0; v < 6; v++) begin
      lat_cfg = tbl[v].lat;
      base  = ren_cnt;
      ubase = und_cnt;
      a = {tbl[v].addr[23:2], 2'b00};
      for (int k = 0; k < tbl[v].nren; k++) begin
        exp_q.push_back(a);
        a = a + 24'd4;
      end
      cap = '0;
      bus.spi_ss = 1'b0;
      repeat (H) @(negedge clk);
      for (int i = 7; i >= 0; i--) clk_bit(tbl[v].cmd[i], 1'b0, m);
      for (int i = 23; i >= 0; i--) clk_bit(tbl[v].addr[i], 1'b0, m);
      for (int i = 0; i < tbl[v].ndum; i++) clk_bit(1'b0, 1'b0, m);
      chk($sformatf("v%0d_ren_before_data", v), 64'(ren_cnt - base),
          64'((tbl[v].nren > 0) ? 1 : 0));
      for (int d = 0; d < tbl[v].dclk; d++) begin
        clk_bit(1'($urandom_range(0, 1)), d == tbl[v].dclk - 1, m);
        cap = {cap[62:0], m};
      end
      repeat (8) @(negedge clk);
      chk($sformatf("v%0d_miso", v), cap, tbl[v].cap);
      chk($sformatf("v%0d_busy_after", v), 64'(bus.busy), 64'd0);
      chk($sformatf("v%0d_underrun", v), 64'(und_cnt - ubase), 64'(tbl[v].nund));
      chk($sformatf("v%0d_ren_count", v), 64'(ren_cnt - base), 64'(tbl[v].nren));
      for (int k = 0; exp_q.size() > 0; k++) begin
        a = exp_q.pop_front();
        if (base + k < ren_cnt)
          chk($sformatf("v%0d_ren_addr%0d", v, k), 64'(ren_log[(base + k) % 256]), 64'(a));
        else
          chk($sformatf("v%0d_ren_addr%0d", v, k), 64'hFFFF_FFFF_FFFF_FFFF, 64'(a));
      end
      repeat (250) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
